// File: rtl/popcount_seq_pkg.sv
// Shared types and width helpers for the time-multiplexed popcount sequencer.
package popcount_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/popcount_core.sv
// Narrow popcount core: combinational bit sum captured in one output register.
module popcount_core #(
    parameter int CORE_W = 16
) (
    input  logic                       clk_i,
    input  logic [CORE_W-1:0]          data_i,
    output logic [$clog2(CORE_W):0]    sum_o
);

    localparam int SUM_W = $clog2(CORE_W) + 1;

    logic [SUM_W-1:0] sum_comb;

    always_comb begin
        sum_comb = '0;
        for (int i = 0; i < CORE_W; i++) begin
            sum_comb = sum_comb + SUM_W'(data_i[i]);
        end
    end

    // No reset: consumers only look at this register behind a valid flag.
    always_ff @(posedge clk_i) begin
        sum_o <= sum_comb;
    end

endmodule

// File: rtl/popcount_sequencer.sv
// Wide-word popcount built from one narrow core stepped over CHUNKS cycles.
//
// state | meaning
// IDLE  | waiting for a word, data_rdy_o high
// FEED  | pushing shadow chunk[idx] into the core, accumulating prior results
// DRAIN | adding the final core result, loading cnt_o
// OUT   | holding cnt_o/cnt_val_o until the consumer takes it
module popcount_sequencer
    import popcount_seq_pkg::*;
#(
    parameter int CORE_W = 16,
    parameter int CHUNKS = 4,
    parameter int DATA_W = CORE_W * CHUNKS,
    parameter int CNT_W  = cnt_width(CORE_W * CHUNKS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              cnt_val_o,
    input  logic              cnt_rdy_i,
    output logic              busy_o
);

    localparam int SUM_W = $clog2(CORE_W) + 1;
    localparam int IDX_W = idx_width(CHUNKS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  acc_q;
    logic              core_vld_q;
    logic [DATA_W-1:0] shadow_q;
    logic [CORE_W-1:0] core_in;
    logic [SUM_W-1:0]  core_sum;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_val_q;
    logic              in_hs;

    assign in_hs      = data_val_i && data_rdy_o;
    assign cnt_o      = cnt_q;
    assign cnt_val_o  = cnt_val_q;
    assign busy_o     = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_rdy_o = 1'b0;
        case (state_q)
            IDLE: begin
                data_rdy_o = 1'b1;
                if (data_val_i) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (idx_q == IDX_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                if (cnt_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow is only read while a word is in flight, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            shadow_q <= data_i;
        end
    end

    always_comb begin
        core_in = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                core_in = shadow_q[k*CORE_W +: CORE_W];
            end
        end
    end

    popcount_core #(
        .CORE_W (CORE_W)
    ) u_core (
        .clk_i  (clk_i),
        .data_i (core_in),
        .sum_o  (core_sum)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q      <= '0;
            acc_q      <= '0;
            core_vld_q <= 1'b0;
            cnt_q      <= '0;
            cnt_val_q  <= 1'b0;
        end else if (in_hs) begin
            idx_q      <= '0;
            acc_q      <= '0;
            core_vld_q <= 1'b0;
        end else begin
            case (state_q)
                FEED: begin
                    if (idx_q != IDX_LAST) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                    core_vld_q <= 1'b1;
                    if (core_vld_q) begin
                        acc_q <= acc_q + CNT_W'(core_sum);
                    end
                end
                DRAIN: begin
                    core_vld_q <= 1'b0;
                    cnt_q      <= acc_q + CNT_W'(core_sum);
                    cnt_val_q  <= 1'b1;
                end
                OUT: begin
                    if (cnt_rdy_i) begin
                        cnt_val_q <= 1'b0;
                    end
                end
                default: begin
                    core_vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Bench for popcount_sequencer: directed cases on the default config plus
// randomized traffic on three configurations against a $countones model.
module tb_popcount_sequencer;

    localparam int NCFG = 3;

    function automatic int cfg_cw(input int g);
        case (g)
            0:       return 16;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_ch(input int g);
        case (g)
            0:       return 4;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] dmask(input int g);
        int dw;
        dw = cfg_cw(g) * cfg_ch(g);
        if (dw >= 64) return '1;
        return (64'd1 << dw) - 64'd1;
    endfunction

    logic        clk;
    logic        rst_n;
    logic [63:0] data     [NCFG];
    logic        data_val [NCFG];
    logic        cnt_rdy  [NCFG];
    logic        data_rdy [NCFG];
    logic        cnt_val  [NCFG];
    logic        busy     [NCFG];
    logic [6:0]  cnt      [NCFG];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int CW = cfg_cw(g);
        localparam int CH = cfg_ch(g);
        localparam int DW = CW * CH;
        localparam int NW = $clog2(DW) + 1;

        logic [DW-1:0] d_w;
        logic [NW-1:0] c_w;
        logic          rdy_w, val_w, busy_w;

        assign d_w         = data[g][DW-1:0];
        assign cnt[g]      = 7'(c_w);
        assign data_rdy[g] = rdy_w;
        assign cnt_val[g]  = val_w;
        assign busy[g]     = busy_w;

        popcount_sequencer #(
            .CORE_W (CW),
            .CHUNKS (CH)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .data_i     (d_w),
            .data_val_i (data_val[g]),
            .data_rdy_o (rdy_w),
            .cnt_o      (c_w),
            .cnt_val_o  (val_w),
            .cnt_rdy_i  (cnt_rdy[g]),
            .busy_o     (busy_w)
        );
    end

    // Waits (bounded) at negedges until the sequencer is ready, then presents w.
    task automatic present_word(input int g, input logic [63:0] w);
        for (int i = 0; i < 200 && !data_rdy[g]; i++) @(negedge clk);
        data[g]     = w;
        data_val[g] = 1'b1;
    endtask

    task automatic wait_result(input int g, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cnt_val[g]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout cnt_val never rose", name);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            data[g] = '0; data_val[g] = 1'b0; cnt_rdy[g] = 1'b1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({data_rdy[0], cnt_val[0], cnt[0], busy[0]} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state rdy=%0b val=%0b cnt=%0d busy=%0b expected rdy=1 val=0 cnt=0 busy=0",
                     data_rdy[0], cnt_val[0], cnt[0], busy[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_latency;
        present_word(0, 64'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) data_val[0] = 1'b0;
            checks++;
            if (cnt_val[0] !== (k == 6) || data_rdy[0] !== (k >= 7) || busy[0] !== (k <= 6)) begin
                errors++;
                $display("FAIL zero_timing k=%0d val=%0b rdy=%0b busy=%0b expected val=%0b rdy=%0b busy=%0b",
                         k, cnt_val[0], data_rdy[0], busy[0], k == 6, k >= 7, k <= 6);
            end
            if (k == 6) begin
                checks++;
                if (cnt[0] !== 7'd0) begin
                    errors++;
                    $display("FAIL zero_count cnt=%0d expected 0", cnt[0]);
                end
            end
        end
    endtask

    task automatic test_all_ones;
        bit ok;
        present_word(0, '1);
        @(negedge clk);
        data_val[0] = 1'b0;
        wait_result(0, "ones", ok);
        if (ok) begin
            checks++;
            if (cnt[0] !== 7'd64) begin
                errors++;
                $display("FAIL ones_count cnt=%0d expected 64", cnt[0]);
            end
            @(negedge clk);
            checks++;
            if (cnt_val[0] !== 1'b0 || data_rdy[0] !== 1'b1) begin
                errors++;
                $display("FAIL ones_pulse val=%0b rdy=%0b expected val=0 rdy=1", cnt_val[0], data_rdy[0]);
            end
        end
    endtask

    task automatic test_shadow;
        bit ok;
        present_word(0, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        data_val[0] = 1'b0;
        data[0]     = '0;
        wait_result(0, "shadow", ok);
        if (ok) begin
            checks++;
            if (cnt[0] !== 7'd32) begin
                errors++;
                $display("FAIL shadow_count cnt=%0d expected 32", cnt[0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit ok;
        cnt_rdy[0] = 1'b0;
        present_word(0, 64'h00FF_00FF_00FF_00FF);
        @(negedge clk);
        data[0] = 64'hFFFF_0000_0000_0000;
        wait_result(0, "bp", ok);
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (cnt[0] !== 7'd32 || cnt_val[0] !== 1'b1 || data_rdy[0] !== 1'b0 || busy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold i=%0d cnt=%0d val=%0b rdy=%0b busy=%0b expected cnt=32 val=1 rdy=0 busy=1",
                             i, cnt[0], cnt_val[0], data_rdy[0], busy[0]);
                end
                @(negedge clk);
            end
            cnt_rdy[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (data_rdy[0] !== 1'b1 || cnt_val[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_release rdy=%0b val=%0b expected rdy=1 val=0", data_rdy[0], cnt_val[0]);
            end
            @(negedge clk);
            data_val[0] = 1'b0;
            wait_result(0, "bp_next", ok);
            if (ok) begin
                checks++;
                if (cnt[0] !== 7'd16) begin
                    errors++;
                    $display("FAIL bp_next_count cnt=%0d expected 16", cnt[0]);
                end
            end
        end
        data_val[0] = 1'b0;
        cnt_rdy[0]  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_feed;
        bit ok;
        bit seen;
        present_word(0, '1);
        @(negedge clk);
        data_val[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_rdy[0], cnt_val[0], cnt[0], busy[0]} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_state rdy=%0b val=%0b cnt=%0d busy=%0b expected rdy=1 val=0 cnt=0 busy=0",
                     data_rdy[0], cnt_val[0], cnt[0], busy[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cnt_val[0] || busy[0]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_ghost saw=1 expected no result and no busy after reset");
        end
        present_word(0, 64'h1);
        @(negedge clk);
        data_val[0] = 1'b0;
        wait_result(0, "midreset_next", ok);
        if (ok) begin
            checks++;
            if (cnt[0] !== 7'd1) begin
                errors++;
                $display("FAIL midreset_next_count cnt=%0d expected 1", cnt[0]);
            end
        end
        @(negedge clk);
    endtask

    // Producer and consumer both randomize; expected counts are queued at accept.
    task automatic test_back_to_back(input int g, input int n);
        int          exp_q[$];
        int          accepted, received, cycles, exp_cnt;
        bit          in_fire;
        logic [63:0] w;
        accepted = 0; received = 0; cycles = 0; in_fire = 1'b0;
        data_val[g] = 1'b0;
        while (received < n && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (in_fire) begin
                data_val[g] = 1'b0;
                in_fire     = 1'b0;
            end
            if (!data_val[g] && accepted < n && $urandom_range(0, 3) != 0) begin
                w           = {$urandom, $urandom} & dmask(g);
                data[g]     = w;
                data_val[g] = 1'b1;
            end
            if (data_val[g] && data_rdy[g]) begin
                exp_q.push_back($countones(data[g] & dmask(g)));
                accepted++;
                in_fire = 1'b1;
            end
            cnt_rdy[g] = ($urandom_range(0, 2) != 0);
            if (cnt_val[g] && cnt_rdy[g]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_cfg%0d_extra cnt=%0d with no word outstanding", g, cnt[g]);
                end else begin
                    exp_cnt = exp_q.pop_front();
                    if (cnt[g] !== 7'(exp_cnt)) begin
                        errors++;
                        $display("FAIL b2b_cfg%0d_count n=%0d cnt=%0d expected %0d", g, received, cnt[g], exp_cnt);
                    end
                end
                received++;
            end
        end
        @(negedge clk);
        data_val[g] = 1'b0;
        cnt_rdy[g]  = 1'b1;
        checks++;
        if (received != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_cfg%0d_total received=%0d outstanding=%0d expected received=%0d outstanding=0",
                     g, received, exp_q.size(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_all_ones();
        test_shadow();
        test_backpressure();
        test_reset_mid_feed();
        for (int g = 0; g < NCFG; g++) test_back_to_back(g, 40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
